qsram_refresh_bank: RTL

//   Parametrised QSRAM bank: DEPTH words of WIDTH bits behind one valid/ready request port.

---
 rtl/qsram_pkg.sv | 17 +
 rtl/qsram_word_array.sv | 32 +++
 rtl/qsram_refresh_bank.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/qsram_pkg.sv
// Shared types and limits for the QSRAM refresh bank.
package qsram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REF_RD = 2'd1,
        REF_WB = 2'd2
    } stateT;

    localparam int MIN_REFRESH_INTERVAL = 3;
    localparam int MIN_DEPTH            = 2;

    function automatic int clampMin(input int value, input int floorValue);
        return (value < floorValue) ? floorValue : value;
    endfunction

endpackage

// File: rtl/qsram_word_array.sv
// DEPTH x WIDTH word storage: one registered read port, one bit-masked write port, no reset.
module qsram_word_array
    import qsram_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             rdEn,
    input  logic [AW-1:0]    rdAddr,
    output logic [WIDTH-1:0] rdQ,
    input  logic             wrEn,
    input  logic [AW-1:0]    wrAddr,
    input  logic [WIDTH-1:0] wrData,
    input  logic [WIDTH-1:0] wrMask
);

    localparam int ROWS = clampMin(DEPTH, MIN_DEPTH);

    logic [WIDTH-1:0] mem [ROWS];

    always_ff @(posedge Clock) begin
        if (wrEn) begin
            mem[wrAddr] <= (mem[wrAddr] & ~wrMask) | (wrData & wrMask);
        end
        if (rdEn) begin
            rdQ <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/qsram_refresh_bank.sv
// QSRAM bank with a valid/ready request port and a round-robin row refresh engine.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | serving requests; starts a refresh when one is pending
//   REF_RD | reading the row at rowPtr into the array output register
//   REF_WB | writing that row back, advancing rowPtr, clearing pending
module qsram_refresh_bank
    import qsram_pkg::*;
#(
    parameter int WIDTH            = 8,
    parameter int DEPTH            = 16,
    parameter int AW               = $clog2(DEPTH),
    parameter int REFRESH_INTERVAL = 16
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic             ReqWrite,
    input  logic [AW-1:0]    ReqAddr,
    input  logic [WIDTH-1:0] ReqData,
    input  logic [WIDTH-1:0] ReqMask,
    output logic             RdValid,
    output logic [WIDTH-1:0] RdData,
    input  logic             RefreshHold,
    output logic             RefreshBusy,
    output logic             RefreshMiss
);

    localparam int            RI          = clampMin(REFRESH_INTERVAL, MIN_REFRESH_INTERVAL);
    localparam int            TW          = $clog2(RI);
    localparam logic [TW-1:0] RELOAD      = TW'(RI - 1);
    localparam logic [AW:0]   DEPTH_LIMIT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ROW    = AW'(DEPTH - 1);

    stateT            state;
    logic [TW-1:0]    timer;
    logic             tick;
    logic             pending;
    logic [AW-1:0]    rowPtr;

    logic             accept;
    logic             inRange;
    logic             arrRdEn;
    logic [AW-1:0]    arrRdAddr;
    logic [WIDTH-1:0] arrRdQ;
    logic             arrWrEn;
    logic [AW-1:0]    arrWrAddr;
    logic [WIDTH-1:0] arrWrData;
    logic [WIDTH-1:0] arrWrMask;
    logic [WIDTH-1:0] hold;

    logic             rdFromArray;
    logic [WIDTH-1:0] savedRd;

    assign tick     = (timer == '0);
    assign ReqReady = (state == IDLE) && !pending;
    assign accept   = ReqValid && ReqReady;
    assign inRange  = ({1'b0, ReqAddr} < DEPTH_LIMIT);
    // The row read in REF_RD lands in the array output register; that is the write-back value.
    assign hold     = arrRdQ;
    assign RdData   = rdFromArray ? arrRdQ : savedRd;

    always_comb begin
        arrRdEn   = 1'b0;
        arrRdAddr = ReqAddr;
        arrWrEn   = 1'b0;
        arrWrAddr = ReqAddr;
        arrWrData = ReqData;
        arrWrMask = ReqMask;
        case (state)
            REF_RD: begin
                arrRdEn   = 1'b1;
                arrRdAddr = rowPtr;
            end
            REF_WB: begin
                arrWrEn   = 1'b1;
                arrWrAddr = rowPtr;
                arrWrData = hold;
                arrWrMask = '1;
            end
            default: begin
                arrRdEn = accept && !ReqWrite && inRange;
                arrWrEn = accept && ReqWrite && inRange;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            timer <= RELOAD;
        end else if (tick) begin
            timer <= RELOAD;
        end else begin
            timer <= timer - 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            pending     <= 1'b0;
            rowPtr      <= '0;
            RefreshBusy <= 1'b0;
            RefreshMiss <= 1'b0;
        end else begin
            // A tick landing in REF_WB re-arms pending for the next row without counting a miss.
            if (tick) begin
                pending <= 1'b1;
                if (pending && state != REF_WB) begin
                    RefreshMiss <= 1'b1;
                end
            end else if (state == REF_WB) begin
                pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pending && !RefreshHold) begin
                        state       <= REF_RD;
                        RefreshBusy <= 1'b1;
                    end
                end
                REF_RD: begin
                    state       <= REF_WB;
                    RefreshBusy <= 1'b1;
                end
                REF_WB: begin
                    state       <= IDLE;
                    RefreshBusy <= 1'b0;
                    rowPtr      <= (rowPtr == LAST_ROW) ? '0 : rowPtr + 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    RefreshBusy <= 1'b0;
                end
            endcase
        end
    end

    // RdData must survive a refresh, which reuses the array output register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            RdValid     <= 1'b0;
            rdFromArray <= 1'b0;
            savedRd     <= '0;
        end else begin
            RdValid <= accept && !ReqWrite;
            if (accept && !ReqWrite) begin
                rdFromArray <= inRange;
                if (!inRange) begin
                    savedRd <= '0;
                end
            end else if (state == REF_RD) begin
                savedRd     <= RdData;
                rdFromArray <= 1'b0;
            end
        end
    end

    qsram_word_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) uArray (
        .Clock  (Clock),
        .rdEn   (arrRdEn),
        .rdAddr (arrRdAddr),
        .rdQ    (arrRdQ),
        .wrEn   (arrWrEn),
        .wrAddr (arrWrAddr),
        .wrData (arrWrData),
        .wrMask (arrWrMask)
    );

endmodule
